// File: rtl/cp0_timer_if.sv
// Pipeline-to-CP0 bus: M-stage exception inputs, MTC0/MFC0 access and CP0 outputs.
// The M stage drives through master; cp0_timer receives through slave.
interface cp0_timer_if #(
    parameter int N_HWINT = 6
);
    logic [4:0]         a_rd;
    logic [4:0]         a_wr;
    logic               we;
    logic [31:0]        din;
    logic [31:0]        pc;
    logic               bd;
    logic [4:0]         exc_code;
    logic [N_HWINT-1:0] hw_int;
    logic               exl_clr;
    logic               int_o;
    logic [31:0]        epc_o;
    logic [31:0]        dout;
    logic               timer_irq;

    modport master (
        output a_rd, a_wr, we, din, pc, bd, exc_code, hw_int, exl_clr,
        input  int_o, epc_o, dout, timer_irq
    );

    modport slave (
        input  a_rd, a_wr, we, din, pc, bd, exc_code, hw_int, exl_clr,
        output int_o, epc_o, dout, timer_irq
    );
endinterface

// File: rtl/cp0_timer.sv
// Coprocessor 0 for the pipelined MIPS core: SR, Cause, EPC and PRID registers,
// plus a Count/Compare timer whose interrupt sits above the external lines.
module cp0_timer #(
    parameter int          N_HWINT   = 6,
    parameter int          COUNT_DIV = 1,
    parameter logic [31:0] PRID_VAL  = 32'h2037_3864
) (
    input  logic        clk,
    input  logic        reset_n,
    cp0_timer_if.slave  bus
);
    localparam int NP = N_HWINT + 1;
    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(COUNT_DIV - 1);

    logic [NP-1:0] r_im;
    logic          r_exl;
    logic          r_ie;
    logic          r_bd;
    logic [NP-1:0] r_ip;
    logic [4:0]    r_ec;
    logic [31:0]   r_epc;
    logic [31:0]   r_count;
    logic [31:0]   r_compare;
    logic [PW-1:0] r_presc;
    logic          r_timer_pend;

    logic [NP-1:0] w_pend;
    logic          w_int_req;
    logic          w_exc_req;
    logic          w_take;
    logic [31:0]   w_new_epc;
    logic [31:0]   w_epc_out;
    logic          w_wr;
    logic          w_wr_sr;
    logic          w_wr_epc;
    logic          w_wr_count;
    logic          w_wr_compare;
    logic          w_inc;
    logic [31:0]   w_count_inc;
    logic [31:0]   w_sr;
    logic [31:0]   w_cause;
    logic [31:0]   w_dout;

    assign w_pend    = {r_timer_pend, bus.hw_int};
    assign w_int_req = (|(w_pend & r_im)) & ~r_exl & r_ie;
    assign w_exc_req = (bus.exc_code != 5'd0) & ~r_exl;
    assign w_take    = w_int_req | w_exc_req;
    assign w_new_epc = bus.bd ? (bus.pc - 32'd4) : bus.pc;
    assign w_epc_out = w_take ? w_new_epc : r_epc;

    // MTC0 is dropped in any cycle that takes an interrupt or exception
    assign w_wr         = bus.we & ~w_take;
    assign w_wr_sr      = w_wr & (bus.a_wr == 5'd12);
    assign w_wr_epc     = w_wr & (bus.a_wr == 5'd14);
    assign w_wr_count   = w_wr & (bus.a_wr == 5'd9);
    assign w_wr_compare = w_wr & (bus.a_wr == 5'd11);

    assign w_inc       = (r_presc == PMAX);
    assign w_count_inc = r_count + 32'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_im  <= '0;
            r_exl <= 1'b0;
            r_ie  <= 1'b0;
            r_bd  <= 1'b0;
            r_ip  <= '0;
            r_ec  <= '0;
            r_epc <= '0;
        end else begin
            r_ip <= w_pend;
            if (w_wr_sr) begin
                r_im  <= bus.din[10 +: NP];
                r_exl <= bus.din[1];
                r_ie  <= bus.din[0];
            end
            if (bus.exl_clr)
                r_exl <= 1'b0;
            if (w_wr_epc)
                r_epc <= bus.din;
            if (w_take) begin
                r_exl <= 1'b1;
                r_ec  <= w_int_req ? 5'd0 : bus.exc_code;
                r_bd  <= bus.bd;
                r_epc <= w_epc_out;
            end
        end
    end

    // A Count write restarts the prescaler and suppresses that cycle's increment and match
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count      <= '0;
            r_compare    <= '1;
            r_presc      <= '0;
            r_timer_pend <= 1'b0;
        end else begin
            if (w_wr_count) begin
                r_count <= bus.din;
                r_presc <= '0;
            end else if (w_inc) begin
                r_count <= w_count_inc;
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 1'b1;
            end

            if (w_wr_compare)
                r_compare <= bus.din;

            if (w_wr_compare)
                r_timer_pend <= 1'b0;
            else if (!w_wr_count && w_inc && (w_count_inc == r_compare))
                r_timer_pend <= 1'b1;
        end
    end

    always_comb begin
        w_sr             = '0;
        w_sr[10 +: NP]   = r_im;
        w_sr[1]          = r_exl;
        w_sr[0]          = r_ie;
        w_cause          = '0;
        w_cause[31]      = r_bd;
        w_cause[10 +: NP] = r_ip;
        w_cause[6:2]     = r_ec;
        case (bus.a_rd)
            5'd9:    w_dout = r_count;
            5'd11:   w_dout = r_compare;
            5'd12:   w_dout = w_sr;
            5'd13:   w_dout = w_cause;
            5'd14:   w_dout = w_epc_out;
            5'd15:   w_dout = PRID_VAL;
            default: w_dout = '0;
        endcase
    end

    assign bus.int_o     = w_take;
    assign bus.epc_o     = {w_epc_out[31:2], 2'b00};
    assign bus.dout      = w_dout;
    assign bus.timer_irq = r_timer_pend;
endmodule
